// File: rtl/param_water_lights_pkg.sv
// rtl/param_water_lights_pkg.sv - shared encodings for the water-lights LED sequencer
package param_water_lights_pkg;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_PING = 2'b10,
        MODE_FILL = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam logic [1:0] FREQ_00 = 2'b00;
    localparam logic [1:0] FREQ_01 = 2'b01;
    localparam logic [1:0] FREQ_10 = 2'b10;
    localparam logic [1:0] FREQ_11 = 2'b11;

endpackage

// File: rtl/param_water_lights_tick_gen.sv
// rtl/param_water_lights_tick_gen.sv - prescaler producing the step condition
module tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W:0]   limit,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Compare with >= so a lowered limit fires on the very next enabled edge.
    assign step = en && ({1'b0, cnt_q} >= (limit - 1'b1));

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_water_lights.sv
// rtl/param_water_lights.sv - parameterised LED sequencer with four patterns and four step rates
module param_water_lights
    import param_water_lights_pkg::*;
#(
    parameter int N_LED = 8,
    parameter int DIV0  = 2,
    parameter int DIV1  = 4,
    parameter int DIV2  = 8,
    parameter int DIV3  = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       freq_set,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam logic [DIV_W:0]   LIM0 = (DIV_W+1)'(DIV0);
    localparam logic [DIV_W:0]   LIM1 = (DIV_W+1)'(DIV1);
    localparam logic [DIV_W:0]   LIM2 = (DIV_W+1)'(DIV2);
    localparam logic [DIV_W:0]   LIM3 = (DIV_W+1)'(DIV3);
    localparam logic [N_LED-1:0] ONE  = {{(N_LED-1){1'b0}}, 1'b1};

    logic [DIV_W:0]   limit;
    logic             step;
    logic [N_LED-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    dir_e             dir_q, dir_d;
    logic             is_onehot;
    logic             is_therm;

    always_comb begin
        limit = LIM0;
        case (freq_set)
            FREQ_00: limit = LIM0;
            FREQ_01: limit = LIM1;
            FREQ_10: limit = LIM2;
            FREQ_11: limit = LIM3;
        endcase
    end

    tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (button),
        .limit (limit),
        .step  (step)
    );

    // A thermometer value has no set bit above a clear one, so adding 1 never overlaps it.
    assign is_onehot = $onehot(led_q);
    assign is_therm  = ((led_q & (led_q + 1'b1)) == '0);

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        tick_d = step;
        if (step) begin
            case (mode)
                MODE_ROL: led_d = is_onehot ? {led_q[N_LED-2:0], led_q[N_LED-1]} : ONE;
                MODE_ROR: led_d = is_onehot ? {led_q[0], led_q[N_LED-1:1]} : ONE;
                MODE_PING: begin
                    if (!is_onehot) begin
                        led_d = ONE;
                    end else if (dir_q == DIR_UP) begin
                        if (led_q[N_LED-1]) begin
                            dir_d = DIR_DOWN;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_UP;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (!is_therm) begin
                        led_d = ONE;
                    end else if (&led_q) begin
                        led_d = '0;
                    end else begin
                        led_d = {led_q[N_LED-2:0], 1'b1};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q  <= ONE;
            tick_q <= 1'b0;
            dir_q  <= DIR_UP;
        end else begin
            led_q  <= led_d;
            tick_q <= tick_d;
            dir_q  <= dir_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_param_water_lights.sv
// tb/tb_param_water_lights.sv - directed self-checking bench with a behavioural reference model
module tb_param_water_lights;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         button = 1'b0;
    logic [1:0]   freq_set = 2'b00;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] led;
    logic         tick;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    param_water_lights #(.N_LED(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .freq_set (freq_set),
        .mode     (mode),
        .led      (led),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pattern tracked as bit position / fill level, rate as cycles per step.
    int m_led  = 1;
    int m_cnt  = 0;
    bit m_up   = 1'b1;
    bit m_tick = 1'b0;

    function automatic int div_of(input logic [1:0] f);
        case (f)
            2'd0: return 2;
            2'd1: return 4;
            2'd2: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int pos_of(input int v);
        for (int i = 0; i < N; i++) if (v == (1 << i)) return i;
        return -1;
    endfunction

    function automatic void next_pat(input int v, input int md, input bit up,
                                     output int nv, output bit nup);
        int p;
        int k;
        p   = pos_of(v);
        k   = $countones(v);
        nv  = v;
        nup = up;
        if (md == 3) begin
            if (v != (1 << k) - 1) nv = 1;
            else nv = (1 << ((k + 1) % (N + 1))) - 1;
        end else if (p < 0) begin
            nv = 1;
        end else if (md == 0) begin
            nv = 1 << ((p + 1) % N);
        end else if (md == 1) begin
            nv = 1 << ((p + N - 1) % N);
        end else begin
            if (up && p == N - 1)      begin nup = 1'b0; p = N - 2; end
            else if (!up && p == 0)    begin nup = 1'b1; p = 1; end
            else if (up)               p = p + 1;
            else                       p = p - 1;
            nv = 1 << p;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        int nv;
        bit nup;
        if (!rst) begin
            m_led  <= 1;
            m_cnt  <= 0;
            m_up   <= 1'b1;
            m_tick <= 1'b0;
        end else begin
            m_tick <= 1'b0;
            if (button) begin
                if (m_cnt + 1 >= div_of(freq_set)) begin
                    next_pat(m_led, int'(mode), m_up, nv, nup);
                    m_led  <= nv;
                    m_up   <= nup;
                    m_cnt  <= 0;
                    m_tick <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_led", int'(led), m_led);
            check("model_tick", int'(tick), int'(m_tick));
        end
    end

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tick && cyc < 100);
        if (!tick) check("tick_timeout", int'(tick), 1);
    endtask

    task automatic run_seq(input string nm, input int exp[$], input int ivl);
        int cyc;
        foreach (exp[i]) begin
            wait_tick(cyc);
            check({nm, "_led"}, int'(led), exp[i]);
            check({nm, "_interval"}, cyc, ivl);
        end
    endtask

    task automatic reset_to(input logic [1:0] m, input logic [1:0] f);
        @(negedge clk);
        rst      = 1'b0;
        mode     = m;
        freq_set = f;
        @(negedge clk);
        rst      = 1'b1;
    endtask

    initial begin
        int cyc;
        #1 rst = 1'b0;
        #2;
        check("reset_led", int'(led), 1);
        check("reset_tick", int'(tick), 0);
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        button = 1'b1;

        run_seq("rol", '{'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h01, 'h02}, 2);

        reset_to(2'b10, 2'b01);
        run_seq("ping", '{'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h40,
                          'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 'h02}, 4);

        reset_to(2'b11, 2'b00);
        run_seq("fill", '{'h03, 'h07, 'h0F, 'h1F, 'h3F, 'h7F, 'hFF, 'h00, 'h01}, 2);

        run_seq("fill_to_07", '{'h03, 'h07}, 2);
        mode = 2'b00;
        run_seq("fill_to_rol", '{'h01}, 2);
        run_seq("rol_to_20", '{'h02, 'h04, 'h08, 'h10, 'h20}, 2);
        mode = 2'b11;
        run_seq("rol_to_fill", '{'h01}, 2);

        mode     = 2'b00;
        freq_set = 2'b11;
        run_seq("slow", '{'h02}, 16);
        repeat (5) @(negedge clk);
        button = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("pause_tick", int'(tick), 0);
            check("pause_led", int'(led), 'h02);
        end
        button = 1'b1;
        wait_tick(cyc);
        check("resume_interval", cyc, 11);
        check("resume_led", int'(led), 'h04);

        repeat (10) @(negedge clk);
        freq_set = 2'b00;
        wait_tick(cyc);
        check("freq_drop_interval", cyc, 1);
        check("freq_drop_led", int'(led), 'h08);

        run_seq("to_10", '{'h10}, 2);
        #2 rst = 1'b0;
        #1;
        check("async_reset_led", int'(led), 1);
        check("async_reset_tick", int'(tick), 0);
        @(negedge clk);
        rst = 1'b1;
        run_seq("restart", '{'h02, 'h04, 'h08}, 2);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
